// File: rtl/i2c_request_arbiter_if.sv
// Client/transmitter-facing signal bundle for i2c_request_arbiter.
// master = arbiter side, slave = client/transmitter side.
interface i2c_request_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [OW-1:0]    owner;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] err;
  logic             tx_start;
  logic             tx_idle;
  logic             busy;

  modport master (
    input  req, tx_idle,
    output grant, owner, done, err, tx_start, busy
  );

  modport slave (
    output req, tx_idle,
    input  grant, owner, done, err, tx_start, busy
  );
endinterface

// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one I2C master transmitter among N_REQ clients:
// start pulse, idle-flag tracking with timeout, done/err pulses, holdoff gap.
module i2c_request_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLDOFF        = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  i2c_request_arbiter_if.master bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RECOVER,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [N_REQ-1:0] r_err, w_err_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic [OW-1:0]    r_rr, w_rr_nxt;

  logic [OW-1:0]    w_pick;
  logic [OW-1:0]    w_rr_after;

  // First asserted request at or after the pointer, wrapping N_REQ-1 -> 0.
  function automatic logic [OW-1:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [OW-1:0]    ptr);
    logic [OW-1:0] pick;
    int            idx;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx[OW-1:0]]) pick = idx[OW-1:0];
    end
    return pick;
  endfunction

  assign w_pick     = f_rr_pick(bus.req, r_rr);
  assign w_rr_after = (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    w_tx_start_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_gap_nxt      = r_gap;
    w_rr_nxt       = r_rr;

    case (r_state)
      S_IDLE: begin
        // tx_idle gate also covers a transmitter still running across a reset.
        if ((|bus.req) && bus.tx_idle) begin
          w_state_nxt    = S_START;
          w_grant_nxt    = N_REQ'(1) << w_pick;
          w_owner_nxt    = w_pick;
          w_tx_start_nxt = 1'b1;
        end
      end

      S_START: begin
        w_state_nxt = S_WAIT_BUSY;
        w_cnt_nxt   = '0;
      end

      S_WAIT_BUSY: begin
        if (!bus.tx_idle) begin
          w_state_nxt = S_WAIT_DONE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CW'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt   = r_grant;
          w_grant_nxt = '0;
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_rr_nxt    = w_rr_after;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (bus.tx_idle) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_rr_nxt    = w_rr_after;
        end else if (r_cnt >= CW'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt   = r_grant;
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_RECOVER: begin
        if (bus.tx_idle) begin
          w_grant_nxt = '0;
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_rr_nxt    = w_rr_after;
        end
      end

      S_GAP: begin
        if (!bus.tx_idle) begin
          w_gap_nxt = '0;
        end else if (r_gap >= GW'(HOLDOFF - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_tx_start <= 1'b0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_rr       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
      r_rr       <= w_rr_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.owner    = r_owner;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.tx_start = r_tx_start;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Bench for i2c_request_arbiter: directed scenarios with literal expectations
// plus a transaction-level reference model compared on every falling edge.
module tb_i2c_request_arbiter;
  localparam int N  = 4;
  localparam int TO = 256;
  localparam int H  = 8;
  localparam int OW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  i2c_request_arbiter_if #(.N_REQ(N)) bus ();

  i2c_request_arbiter #(
    .N_REQ(N), .TIMEOUT_CYCLES(TO), .HOLDOFF(H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the client-visible outputs must be after each edge.
  typedef enum {M_FREE, M_LAUNCH, M_AWAIT_START, M_IN_FLIGHT, M_DRAIN, M_HOLDOFF} mphase_t;
  mphase_t          ph = M_FREE;
  int               el = 0;
  int               m_rr = 0;
  int               e_owner = 0;
  logic [N-1:0]     e_grant = '0, e_done = '0, e_err = '0;
  logic             e_tx_start = 1'b0, e_busy = 1'b0;
  bit               started = 0;

  function automatic int m_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return 0;
  endfunction

  always @(posedge clock) begin
    started = 1;
    if (!reset) begin
      ph = M_FREE; el = 0; m_rr = 0; e_owner = 0;
      e_grant = '0; e_done = '0; e_err = '0; e_tx_start = 1'b0;
    end else begin
      e_done = '0; e_err = '0; e_tx_start = 1'b0;
      case (ph)
        M_FREE:
          if (bus.req != '0 && bus.tx_idle) begin
            e_owner = m_pick(bus.req, m_rr);
            e_grant = 4'b0001 << e_owner;
            e_tx_start = 1'b1;
            ph = M_LAUNCH;
          end
        M_LAUNCH: begin ph = M_AWAIT_START; el = 0; end
        M_AWAIT_START:
          if (!bus.tx_idle) begin ph = M_IN_FLIGHT; el = 0; end
          else begin
            el++;
            if (el == TO) begin
              e_err = e_grant; e_grant = '0;
              ph = M_HOLDOFF; el = 0; m_rr = (e_owner + 1) % N;
            end
          end
        M_IN_FLIGHT:
          if (bus.tx_idle) begin
            e_done = e_grant; e_grant = '0;
            ph = M_HOLDOFF; el = 0; m_rr = (e_owner + 1) % N;
          end else begin
            el++;
            if (el == TO) begin e_err = e_grant; ph = M_DRAIN; end
          end
        M_DRAIN:
          if (bus.tx_idle) begin
            e_grant = '0; ph = M_HOLDOFF; el = 0; m_rr = (e_owner + 1) % N;
          end
        M_HOLDOFF:
          if (!bus.tx_idle) el = 0;
          else begin
            el++;
            if (el == H) ph = M_FREE;
          end
        default: ph = M_FREE;
      endcase
    end
    e_busy = (ph != M_FREE);
  end

  always @(negedge clock) begin
    if (started) begin
      chk("sb_grant",    bus.grant,    e_grant);
      chk("sb_owner",    bus.owner,    e_owner);
      chk("sb_done",     bus.done,     e_done);
      chk("sb_err",      bus.err,      e_err);
      chk("sb_tx_start", bus.tx_start, e_tx_start);
      chk("sb_busy",     bus.busy,     e_busy);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return bus.grant != '0;
      1: return bus.done  != '0;
      2: return bus.err   != '0;
      default: return bus.busy == 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int bound, output int cycles);
    cycles = 0;
    while (!cond(which) && cycles < bound) begin
      @(negedge clock);
      cycles++;
    end
    if (!cond(which)) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: condition not seen within %0d cycles", name, bound);
    end
  endtask

  int ord[5] = '{1, 2, 4, 8, 1};
  int c;
  logic [N-1:0] g;

  initial begin
    bus.req = '0;
    bus.tx_idle = 1'b1;
    reset = 1'b0;
    cyc(3);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_owner", bus.owner, 0);
    reset = 1'b1;
    cyc(2);

    // Single transaction from requester 1.
    bus.req = 4'b0010;
    cyc(1);
    chk("t1_grant", bus.grant, 4'b0010);
    chk("t1_tx_start", bus.tx_start, 1);
    chk("t1_owner", bus.owner, 1);
    cyc(1);
    chk("t1_tx_start_width", bus.tx_start, 0);
    cyc(1);
    bus.tx_idle = 1'b0;
    cyc(200);
    bus.tx_idle = 1'b1;
    cyc(1);
    chk("t1_done", bus.done, 4'b0010);
    chk("t1_grant_clr", bus.grant, 0);
    bus.req = '0;
    wait_for("t1_busy_low", 3, 50, c);
    chk("t1_holdoff_len", c, H);

    // All four requesting: rotation from pointer 0; last owner drops req mid-transfer.
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_for("t2_grant", 0, 30, c);
      chk("t2_order", bus.grant, ord[t]);
      g = bus.grant;
      cyc(2);
      bus.tx_idle = 1'b0;
      cyc(5);
      if (t == 4) bus.req = 4'b1110;
      cyc(3);
      if (t == 4) chk("t2_hold_after_drop", bus.grant, 4'b0001);
      bus.tx_idle = 1'b1;
      wait_for("t2_done", 1, 5, c);
      chk("t2_done_owner", bus.done, g);
    end
    bus.req = '0;
    wait_for("t2_idle", 3, 20, c);

    // Owner 2 completes with 0 and 2 pending: pointer 3 wraps to requester 0.
    bus.req = 4'b0100;
    wait_for("t3_grant", 0, 10, c);
    chk("t3_grant2", bus.grant, 4'b0100);
    bus.req = 4'b0101;
    cyc(2);
    bus.tx_idle = 1'b0;
    cyc(4);
    bus.tx_idle = 1'b1;
    wait_for("t3_done", 1, 5, c);
    chk("t3_done2", bus.done, 4'b0100);
    wait_for("t3_next", 0, 30, c);
    chk("t3_wrap", bus.grant, 4'b0001);
    bus.req = '0;
    cyc(2);
    bus.tx_idle = 1'b0;
    cyc(3);
    bus.tx_idle = 1'b1;
    wait_for("t3_done0", 1, 5, c);
    chk("t3_done0_owner", bus.done, 4'b0001);
    wait_for("t3_idle", 3, 20, c);

    // Transmitter never leaves idle: err after TO cycles in WAIT_BUSY.
    bus.req = 4'b1000;
    wait_for("t4_grant", 0, 10, c);
    chk("t4_grant3", bus.grant, 4'b1000);
    wait_for("t4_err", 2, 400, c);
    chk("t4_err_time", c, TO + 1);
    chk("t4_err_owner", bus.err, 4'b1000);
    chk("t4_no_done", bus.done, 0);
    chk("t4_grant_clr", bus.grant, 0);
    bus.req = '0;
    wait_for("t4_idle", 3, 20, c);

    // Transmitter stuck busy: err, then RECOVER holds grant until idle returns.
    bus.req = 4'b0010;
    wait_for("t5_grant", 0, 10, c);
    chk("t5_grant1", bus.grant, 4'b0010);
    cyc(2);
    bus.tx_idle = 1'b0;
    wait_for("t5_err", 2, 400, c);
    chk("t5_err_owner", bus.err, 4'b0010);
    chk("t5_grant_held", bus.grant, 4'b0010);
    cyc(20);
    chk("t5_recover_busy", bus.busy, 1);
    chk("t5_recover_grant", bus.grant, 4'b0010);
    bus.tx_idle = 1'b1;
    cyc(1);
    chk("t5_release", bus.grant, 0);
    chk("t5_no_done", bus.done, 0);
    bus.req = '0;
    wait_for("t5_idle", 3, 20, c);

    // Reset mid-transfer; no new grant until the transmitter reports idle.
    bus.req = 4'b0001;
    wait_for("t6_grant", 0, 10, c);
    chk("t6_grant0", bus.grant, 4'b0001);
    cyc(2);
    bus.tx_idle = 1'b0;
    cyc(10);
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_grant", bus.grant, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_owner", bus.owner, 0);
    reset = 1'b1;
    bus.req = 4'b1111;
    cyc(10);
    chk("t6_blocked_grant", bus.grant, 0);
    chk("t6_blocked_busy", bus.busy, 0);
    bus.tx_idle = 1'b1;
    cyc(1);
    chk("t6_regrant", bus.grant, 4'b0001);
    bus.req = '0;
    cyc(2);
    bus.tx_idle = 1'b0;
    cyc(3);
    bus.tx_idle = 1'b1;
    cyc(1);
    chk("t6_done", bus.done, 4'b0001);
    wait_for("t6_idle", 3, 20, c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
